// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Op encodings follow funct3[1:0] of DIV/DIVU/REM/REMU.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LZA,
    ST_LZB,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } div_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: conditional subtract, quotient bit insert, divisor shift.
module div_restore_step (
  input  logic [31:0] i_rem,
  input  logic [63:0] i_div,
  input  logic [31:0] i_quo,
  output logic [31:0] o_rem,
  output logic [63:0] o_div,
  output logic [31:0] o_quo
);

  logic w_ge;

  // The divisor may still sit above bit 31 early in a full 32-step run.
  assign w_ge  = ({32'd0, i_rem} >= i_div);
  assign o_rem = w_ge ? (i_rem - i_div[31:0]) : i_rem;
  assign o_quo = {i_quo[30:0], w_ge};
  assign o_div = i_div >> 1;

endmodule

// File: rtl/leading_zero_counter_32bit.sv
// Leading-zero count of a 32-bit word; o_NLZ is only meaningful when o_all_zero is low.
module leading_zero_counter_32bit (
  input  logic [31:0] i_data,
  output logic [4:0]  o_NLZ,
  output logic        o_all_zero
);

  // Later (higher) set bits override earlier ones, leaving the MSB-most position.
  always_comb begin
    o_NLZ = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_NLZ = 5'(31 - i);
    end
  end

  assign o_all_zero = (i_data == 32'd0);

endmodule

// File: rtl/div_lzc_sequencer.sv
// Iterative RV32M divider with leading-zero-count early-out and valid/ready handshakes.
// One LZC is shared: dividend magnitude counted in LZA, divisor magnitude in LZB.
module div_lzc_sequencer
  import div_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic        o_busy
);

  div_state_e  r_state;
  div_op_e     r_op;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_q;
  logic [31:0] r_r;
  logic [63:0] r_d;
  logic [5:0]  r_nz_a;
  logic [5:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_valid;

  logic [31:0] w_lzc_in;
  logic [4:0]  w_nlz;
  logic        w_all_zero;
  logic [5:0]  w_nz;
  logic        w_signed;
  logic [31:0] w_rs1_mag;
  logic [31:0] w_rs2_mag;
  logic        w_ovf;
  logic        w_early;
  logic [5:0]  w_k;
  logic [4:0]  w_shamt;
  logic [31:0] w_step_r;
  logic [63:0] w_step_d;
  logic [31:0] w_step_q;
  logic [31:0] w_fix_q;
  logic [31:0] w_fix_r;

  assign w_lzc_in = (r_state == ST_LZA) ? r_a : r_b;

  leading_zero_counter_32bit u_lzc (
    .i_data     (w_lzc_in),
    .o_NLZ      (w_nlz),
    .o_all_zero (w_all_zero)
  );

  assign w_nz      = w_all_zero ? 6'd32 : {1'b0, w_nlz};
  assign w_signed  = ~i_op[0];
  assign w_rs1_mag = (w_signed && i_rs1[31]) ? (32'd0 - i_rs1) : i_rs1;
  assign w_rs2_mag = (w_signed && i_rs2[31]) ? (32'd0 - i_rs2) : i_rs2;
  assign w_ovf     = w_signed && (i_rs1 == INT_MIN) && (i_rs2 == 32'hFFFF_FFFF);

  // In LZB w_nz is the divisor count; fewer divisor zeros means divisor > dividend.
  assign w_early = EARLY_OUT && (w_nz < r_nz_a);
  assign w_k     = EARLY_OUT ? (w_nz - r_nz_a + 6'd1) : 6'd32;
  assign w_shamt = EARLY_OUT ? 5'(w_nz - r_nz_a) : 5'd31;

  div_restore_step u_step (
    .i_rem (r_r),
    .i_div (r_d),
    .i_quo (r_q),
    .o_rem (w_step_r),
    .o_div (w_step_d),
    .o_quo (w_step_q)
  );

  assign w_fix_q = r_neg_q ? (32'd0 - r_q) : r_q;
  assign w_fix_r = r_neg_r ? (32'd0 - r_r) : r_r;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_DIV;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_q      <= 32'd0;
      r_r      <= 32'd0;
      r_d      <= 64'd0;
      r_nz_a   <= 6'd0;
      r_cnt    <= 6'd0;
      r_result <= 32'd0;
      r_valid  <= 1'b0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_op    <= div_op_e'(i_op);
            r_neg_q <= w_signed && (i_rs1[31] ^ i_rs2[31]);
            r_neg_r <= w_signed && i_rs1[31];
            r_a     <= w_rs1_mag;
            r_b     <= w_rs2_mag;
            if (i_rs2 == 32'd0) begin
              r_result <= i_op[1] ? i_rs1 : DIV_BY_ZERO_Q;
              r_valid  <= 1'b1;
              r_state  <= ST_DONE;
            end else if (w_ovf) begin
              r_result <= i_op[1] ? 32'd0 : INT_MIN;
              r_valid  <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_state <= ST_LZA;
            end
          end
        end
        ST_LZA: begin
          r_nz_a  <= w_nz;
          r_state <= ST_LZB;
        end
        ST_LZB: begin
          r_q <= 32'd0;
          r_r <= r_a;
          if (w_early) begin
            r_state <= ST_FIX;
          end else begin
            r_d     <= {32'd0, r_b} << w_shamt;
            r_cnt   <= w_k;
            r_state <= ST_ITER;
          end
        end
        ST_ITER: begin
          r_r   <= w_step_r;
          r_q   <= w_step_q;
          r_d   <= w_step_d;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) r_state <= ST_FIX;
        end
        ST_FIX: begin
          case (r_op)
            OP_DIV:  r_result <= w_fix_q;
            OP_DIVU: r_result <= r_q;
            OP_REM:  r_result <= w_fix_r;
            default: r_result <= r_r;
          endcase
          r_valid <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready  = (r_state == ST_IDLE);
  assign o_busy   = (r_state != ST_IDLE);
  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule

// File: tb/tb_div_lzc_sequencer.sv
// Directed bench for div_lzc_sequencer: results, latencies, back-pressure, flush and reset.
module tb_div_lzc_sequencer;

  logic        clk = 1'b0;
  logic        rst, flush, valid, valid0, ready;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        rdy, ov, busy, rdy0, ov0, busy0;
  logic [31:0] res, res0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  div_lzc_sequencer #(.EARLY_OUT(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy),
    .i_op(op), .i_rs1(rs1), .i_rs2(rs2), .o_valid(ov), .i_ready(ready),
    .o_result(res), .o_busy(busy)
  );

  div_lzc_sequencer #(.EARLY_OUT(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid0), .o_ready(rdy0),
    .i_op(op), .i_rs1(rs1), .i_rs2(rs2), .o_valid(ov0), .i_ready(ready),
    .o_result(res0), .o_busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then count negedges from the accept edge until o_valid is seen.
  task automatic run(input bit use0, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                     input string tag);
    int guard;
    int lat;
    guard = 0;
    @(negedge clk);
    while (!(use0 ? rdy0 : rdy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " ready"}, 32'(use0 ? rdy0 : rdy), 32'd1);
    op = o; rs1 = a; rs2 = b;
    if (use0) valid0 = 1'b1; else valid = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      valid = 1'b0; valid0 = 1'b0;
      lat++;
    end while (!(use0 ? ov0 : ov) && lat < 100);
    chk({tag, " result"}, use0 ? res0 : res, exp);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    $display("txn %-18s op=%0d a=%h b=%h result=%h latency=%0d", tag, o, a, b,
             use0 ? res0 : res, lat);
  endtask

  task automatic abort_midway(input bit use_rst, input string tag);
    bit seen;
    @(negedge clk);
    op = 2'b01; rs1 = 32'd100; rs2 = 32'd7; valid = 1'b1;
    @(posedge clk);
    @(negedge clk); valid = 1'b0;     // LZA
    @(negedge clk);                   // LZB
    @(negedge clk);                   // ITER step 1
    @(negedge clk);                   // ITER step 2
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " valid"}, 32'(ov), 32'd0);
    if (use_rst) chk({tag, " result"}, res, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov) seen = 1'b1;
    end
    chk({tag, " no stray valid"}, 32'(seen), 32'd0);
    $display("txn %-18s aborted in ITER, busy=%0d valid=%0d", tag, busy, ov);
    run(1'b0, 2'b01, 32'd9, 32'd3, 32'd3, 7, {tag, " 9/3"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; valid0 = 1'b0; ready = 1'b1;
    op = 2'b00; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset valid", 32'(ov), 32'd0);
    chk("reset result", res, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ready", 32'(rdy), 32'd1);

    run(1'b0, 2'b01, 32'd100, 32'd7, 32'd14, 9, "DIVU 100/7");
    run(1'b0, 2'b11, 32'd100, 32'd7, 32'd2, 9, "REMU 100/7");
    run(1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 6, "DIV -7/2");
    run(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 6, "REM -7/2");
    run(1'b0, 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 6, "DIV -7/-2");
    run(1'b0, 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIVU 5/0");
    run(1'b0, 2'b10, 32'd5, 32'd0, 32'd5, 1, "REM 5/0");
    run(1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf");
    run(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "REM ovf");
    run(1'b0, 2'b01, 32'd3, 32'd10, 32'd0, 4, "DIVU 3/10");
    run(1'b0, 2'b11, 32'd3, 32'd10, 32'd3, 4, "REMU 3/10");
    run(1'b0, 2'b01, 32'd0, 32'd9, 32'd0, 4, "DIVU 0/9");
    run(1'b1, 2'b01, 32'd100, 32'd7, 32'd14, 36, "DIVU 100/7 full");
    run(1'b1, 2'b11, 32'd100, 32'd7, 32'd2, 36, "REMU 100/7 full");

    // Back-pressure: result must hold while the consumer stalls, new requests ignored.
    ready = 1'b0;
    run(1'b0, 2'b01, 32'd100, 32'd7, 32'd14, 9, "DIVU stalled");
    op = 2'b01; rs1 = 32'd50; rs2 = 32'd5; valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold valid", 32'(ov), 32'd1);
      chk("hold result", res, 32'd14);
      chk("hold ready", 32'(rdy), 32'd0);
    end
    valid = 1'b0; ready = 1'b1;
    @(negedge clk);
    chk("release ready", 32'(rdy), 32'd1);
    chk("release valid", 32'(ov), 32'd0);
    @(negedge clk);
    chk("release idle", 32'(busy), 32'd0);
    $display("txn %-18s held 3 cycles, released", "backpressure");

    // A flush in IDLE drops the request presented in the same cycle.
    op = 2'b01; rs1 = 32'd8; rs2 = 32'd2; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    chk("idle flush busy", 32'(busy), 32'd0);
    chk("idle flush valid", 32'(ov), 32'd0);
    $display("txn %-18s request dropped, busy=%0d", "idle flush", busy);

    abort_midway(1'b0, "flush");
    abort_midway(1'b1, "reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
